fresh_data_arbiter: RTL

- Collects "data refreshed" events from N_CH independent producers. A producer signals an event with a rising edge on its dataIn bit.
- Latches each producer's data word at its event.
- Hands the latched words one at a time to a single shared downstream consumer over a valid/ready handshake, using round-robin fairness.
- Sits between the per-channel fresh-data sources and the shared capture/processing datapath, and sequences access to that datapath.

---
 rtl/fresh_data_arbiter_pkg.sv | 20 ++
 rtl/fresh_data_latch.sv | 49 ++++
 rtl/fresh_data_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/fresh_data_arbiter_pkg.sv
// Shared definitions for the channel-scheduling blocks: FSM state encoding
// and the index-width helper used to size channel selectors.
package fresh_data_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } fda_state_e;

    // Number of bits needed to index n items (n >= 2).
    function automatic int fda_clog2(input int n);
        int r;
        r = 0;
        for (int p = 1; p < n; p = p * 2) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fresh_data_latch.sv
// Per-channel front end: detects the refresh edge, captures the word,
// tracks whether it still awaits issue and flags words lost to overwrite.
module fresh_data_latch #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          din,
    input  logic [DW-1:0] din_data,
    input  logic          issue,
    input  logic          ov_clr,
    output logic [DW-1:0] hold,
    output logic          pending,
    output logic          overrun
);

    logic prev_reg;
    logic edge_w;

    assign edge_w = din & ~prev_reg;

    // Edge history, word capture, pending flag (a new edge outranks an issue
    // so a word arriving while the old one is taken stays queued) and the
    // sticky overrun flag (a set outranks the clear).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_reg <= 1'b0;
            hold     <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            prev_reg <= din;
            if (edge_w) begin
                hold <= din_data;
            end
            if (edge_w) begin
                pending <= 1'b1;
            end else if (issue) begin
                pending <= 1'b0;
            end
            if (edge_w && pending && !issue) begin
                overrun <= 1'b1;
            end else if (ov_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fresh_data_arbiter.sv
// Collects refresh events from N_CH producers and hands the latched words,
// one at a time in round-robin order, to a single valid/ready consumer.
module fresh_data_arbiter
    import fresh_data_arbiter_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int DW   = 16,
    localparam int CW   = fda_clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_CH-1:0]  dataIn,
    input  logic [N_CH*DW-1:0] chData,
    output logic             outValid,
    input  logic             outReady,
    output logic [DW-1:0]    outData,
    output logic [CW-1:0]    outCh,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  overrun,
    input  logic             ovClr
);

    fda_state_e      state_reg;
    logic [CW-1:0]   last_reg;
    logic [CW-1:0]   sel_next;
    logic            any_pending;
    logic            do_issue;
    logic [N_CH-1:0] issue_w;
    logic [DW-1:0]   hold_w [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            fresh_data_latch #(.DW(DW)) u_latch (
                .clk      (clk),
                .rstn     (rstn),
                .din      (dataIn[gi]),
                .din_data (chData[gi*DW +: DW]),
                .issue    (issue_w[gi]),
                .ov_clr   (ovClr),
                .hold     (hold_w[gi]),
                .pending  (pending[gi]),
                .overrun  (overrun[gi])
            );
            assign issue_w[gi] = do_issue && (sel_next == CW'(gi));
        end
    endgenerate

    assign any_pending = |pending;
    assign do_issue    = any_pending &&
                         ((state_reg == ST_IDLE) || (state_reg == ST_OFFER && outReady));

    // Round-robin pick: first pending channel after the last grant, wrapping.
    always_comb begin : sel_comb
        int            idx;
        logic [CW-1:0] idx_c;
        logic          found;
        sel_next = last_reg;
        idx      = 0;
        idx_c    = '0;
        found    = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last_reg) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            idx_c = CW'(idx);
            if (!found && pending[idx_c]) begin
                found    = 1'b1;
                sel_next = idx_c;
            end
        end
    end

    // Offer FSM with registered outputs; an accepted word is replaced in the
    // same clock when another is pending, so bursts have no bubbles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            last_reg  <= CW'(N_CH - 1);
            outValid  <= 1'b0;
            outData   <= '0;
            outCh     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_pending) begin
                        outData   <= hold_w[sel_next];
                        outCh     <= sel_next;
                        last_reg  <= sel_next;
                        outValid  <= 1'b1;
                        state_reg <= ST_OFFER;
                    end else begin
                        outValid  <= 1'b0;
                    end
                end
                ST_OFFER: begin
                    if (outReady) begin
                        if (any_pending) begin
                            outData  <= hold_w[sel_next];
                            outCh    <= sel_next;
                            last_reg <= sel_next;
                            outValid <= 1'b1;
                        end else begin
                            outValid  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    outValid  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
